// File: rtl/quote_egress_queue_pkg.sv
// Shared types for the quote egress queue: output FSM states, beat side
// encoding and the queued entry layout.
package egress_pkg;

    // Entry payload geometry; the top's REG_WIDTH/NUM_REGS must match these.
    localparam int PKG_REG_WIDTH = 32;
    localparam int PKG_NUM_REGS  = 9;
    // Stored id is wide enough for up to 256 symbols; the top uses the low bits.
    localparam int PKG_ID_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND_BUY,
        SEND_SELL
    } state_e;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef logic [PKG_NUM_REGS-1:0][PKG_REG_WIDTH-1:0] bundle_t;

    typedef struct packed {
        logic [PKG_ID_WIDTH-1:0] stock_id;
        bundle_t                 regs_b;
        bundle_t                 regs_s;
    } entry_t;

endpackage

// File: rtl/quote_egress_queue_if.sv
// Quote input and beat output bundle of the egress queue.
interface quote_egress_queue_if #(
    parameter int REG_WIDTH      = 32,
    parameter int NUM_REGS       = 9,
    parameter int NUM_STOCKS     = 4,
    parameter int DEPTH          = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int STOCK_ID_WIDTH = $clog2(NUM_STOCKS)
);
    logic                                 i_valid;
    logic [STOCK_ID_WIDTH-1:0]            i_stock_id;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]   i_regs_b;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]   i_regs_s;
    logic [NUM_STOCKS-1:0]                i_enable_mask;
    logic                                 i_ready;
    logic                                 o_valid;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0]   o_regs;
    logic                                 o_side;
    logic [STOCK_ID_WIDTH-1:0]            o_stock_id;
    logic [$clog2(DEPTH):0]               o_count;
    logic [CNT_WIDTH-1:0]                 o_drop_count;
    logic [CNT_WIDTH-1:0]                 o_supersede_count;
    logic                                 o_overflow;

    modport master (
        output i_valid, i_stock_id, i_regs_b, i_regs_s, i_enable_mask, i_ready,
        input  o_valid, o_regs, o_side, o_stock_id, o_count,
               o_drop_count, o_supersede_count, o_overflow
    );

    modport slave (
        input  i_valid, i_stock_id, i_regs_b, i_regs_s, i_enable_mask, i_ready,
        output o_valid, o_regs, o_side, o_stock_id, o_count,
               o_drop_count, o_supersede_count, o_overflow
    );
endinterface

// File: rtl/quote_egress_queue_slot_ram.sv
// DEPTH-entry quote storage: one synchronous write port, combinational read.
module quote_slot_ram
    import egress_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  entry_t           wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output entry_t           rdata_o
);
    entry_t mem_q [DEPTH];

    // Write port: append or in-place supersede.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/quote_egress_queue.sv
// Egress queue for buy/sell quote pairs: per-symbol in-place supersede,
// drop-on-full accounting, and a buy-then-sell beat FSM toward the network.
module quote_egress_queue
    import egress_pkg::*;
#(
    parameter int REG_WIDTH      = PKG_REG_WIDTH,
    parameter int NUM_REGS       = PKG_NUM_REGS,
    parameter int NUM_STOCKS     = 4,
    parameter int DEPTH          = 8,
    parameter int STOCK_ID_WIDTH = $clog2(NUM_STOCKS),
    parameter int CNT_WIDTH      = 16
) (
    input logic            i_clk,
    input logic            i_reset_n,
    quote_egress_queue_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNTQ_W = PTR_W + 1;

    state_e                    state_q, state_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTQ_W-1:0]         count_q, count_d;
    logic [NUM_STOCKS-1:0]     pending_q, pending_d;
    logic [PTR_W-1:0]          slot_q [NUM_STOCKS];
    logic [PTR_W-1:0]          slot_d [NUM_STOCKS];
    bundle_t                   out_b_q, out_b_d, out_s_q, out_s_d;
    logic [STOCK_ID_WIDTH-1:0] out_id_q, out_id_d;
    logic [CNT_WIDTH-1:0]      drop_q, drop_d, sup_q, sup_d;
    logic                      ovf_q, ovf_d;

    entry_t                    head, wentry;
    logic                      we;
    logic [PTR_W-1:0]          waddr;
    logic                      pop, accept, pop_same, do_sup, do_app, do_drop;
    logic [STOCK_ID_WIDTH-1:0] in_id, head_id;
    logic [NUM_REGS-1:0][REG_WIDTH-1:0] regs_b_in, regs_s_in;
    logic                      unused_id_bits;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    quote_slot_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (i_clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wentry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign in_id     = bus.i_stock_id;
    assign regs_b_in = bus.i_regs_b;
    assign regs_s_in = bus.i_regs_s;
    assign head_id   = STOCK_ID_WIDTH'(head.stock_id);
    // Stored id bits above STOCK_ID_WIDTH are always written as zero.
    assign unused_id_bits = ^head.stock_id;

    // A head pop of the same symbol takes the old payload; the new quote is appended.
    assign accept   = bus.i_valid && bus.i_enable_mask[in_id];
    assign pop_same = pop && (head_id == in_id);
    assign do_sup   = accept && pending_q[in_id] && !pop_same;
    assign do_app   = accept && !do_sup && ((count_q < CNTQ_W'(DEPTH)) || pop);
    assign do_drop  = accept && !do_sup && !do_app;

    // Output FSM: pops the head into the beat register when a pair can start.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        out_b_d  = out_b_q;
        out_s_d  = out_s_q;
        out_id_d = out_id_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = SEND_BUY;
                end
            end
            SEND_BUY: begin
                if (bus.i_ready) state_d = SEND_SELL;
            end
            SEND_SELL: begin
                if (bus.i_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = SEND_BUY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            out_b_d  = head.regs_b;
            out_s_d  = head.regs_s;
            out_id_d = head_id;
        end
    end

    // Queue bookkeeping: write port, pointers, occupancy, per-symbol tracking, counters.
    always_comb begin
        wentry          = '0;
        wentry.stock_id = PKG_ID_WIDTH'(in_id);
        wentry.regs_b   = regs_b_in;
        wentry.regs_s   = regs_s_in;
        we        = do_sup || do_app;
        waddr     = do_sup ? slot_q[in_id] : wr_ptr_q;
        wr_ptr_d  = do_app ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNTQ_W'(do_app) - CNTQ_W'(pop);
        pending_d = pending_q;
        slot_d    = slot_q;
        if (pop) pending_d[head_id] = 1'b0;
        if (do_app) begin
            pending_d[in_id] = 1'b1;
            slot_d[in_id]    = wr_ptr_q;
        end
        drop_d = do_drop ? sat_inc(drop_q) : drop_q;
        sup_d  = do_sup ? sat_inc(sup_q) : sup_q;
        ovf_d  = ovf_q | do_drop;
    end

    // State and datapath registers; reset discards the queue and the beat in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            for (int s = 0; s < NUM_STOCKS; s++) slot_q[s] <= '0;
            out_b_q   <= '0;
            out_s_q   <= '0;
            out_id_q  <= '0;
            drop_q    <= '0;
            sup_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            slot_q    <= slot_d;
            out_b_q   <= out_b_d;
            out_s_q   <= out_s_d;
            out_id_q  <= out_id_d;
            drop_q    <= drop_d;
            sup_q     <= sup_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.o_valid           = (state_q != IDLE);
    assign bus.o_side            = (state_q == SEND_SELL) ? SIDE_SELL : SIDE_BUY;
    assign bus.o_regs            = (state_q == SEND_SELL) ? out_s_q : out_b_q;
    assign bus.o_stock_id        = out_id_q;
    assign bus.o_count           = count_q;
    assign bus.o_drop_count      = drop_q;
    assign bus.o_supersede_count = sup_q;
    assign bus.o_overflow        = ovf_q;
endmodule

// File: tb/tb_quote_egress_queue.sv
// Bench for quote_egress_queue: queue-level reference model compared every
// cycle, plus directed scenarios with hand-derived expectations.
module tb_quote_egress_queue;
    localparam int RW = 32, NR = 9, NS = 16, DP = 8, IDW = 4, CW = 16;

    typedef logic [NR-1:0][RW-1:0] bundle_t;
    typedef struct {
        logic [IDW-1:0] id;
        bundle_t        b;
        bundle_t        s;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    quote_egress_queue_if #(.REG_WIDTH(RW), .NUM_REGS(NR), .NUM_STOCKS(NS),
                            .DEPTH(DP), .CNT_WIDTH(CW)) bus ();

    quote_egress_queue #(.REG_WIDTH(RW), .NUM_REGS(NR), .NUM_STOCKS(NS),
                         .DEPTH(DP), .CNT_WIDTH(CW)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    task automatic chk(input string name, input logic [NR*RW-1:0] act,
                       input logic [NR*RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the queue as an ordered list, the pair in flight and its phase.
    pair_t mq[$];
    pair_t cur;
    int    phase;   // 0 none, 1 buy beat shown, 2 sell beat shown
    int    m_drop, m_sup;
    bit    m_ovf;

    task automatic model_reset();
        mq.delete();
        phase  = 0;
        m_drop = 0;
        m_sup  = 0;
        m_ovf  = 0;
    endtask

    // Advance by one clock edge with the inputs currently applied.
    task automatic model_step();
        int    hit;
        pair_t np;
        if (phase == 0) begin
            if (mq.size() > 0) begin cur = mq.pop_front(); phase = 1; end
        end else if (phase == 1) begin
            if (bus.i_ready) phase = 2;
        end else if (bus.i_ready) begin
            if (mq.size() > 0) begin cur = mq.pop_front(); phase = 1; end
            else phase = 0;
        end
        if (bus.i_valid && bus.i_enable_mask[bus.i_stock_id]) begin
            hit = -1;
            foreach (mq[j]) if (mq[j].id == bus.i_stock_id) hit = j;
            if (hit >= 0) begin
                mq[hit].b = bus.i_regs_b;
                mq[hit].s = bus.i_regs_s;
                if (m_sup < (1 << CW) - 1) m_sup++;
            end else if (mq.size() < DP) begin
                np.id = bus.i_stock_id;
                np.b  = bus.i_regs_b;
                np.s  = bus.i_regs_s;
                mq.push_back(np);
            end else begin
                if (m_drop < (1 << CW) - 1) m_drop++;
                m_ovf = 1'b1;
            end
        end
    endtask

    // Compare on the falling edge, then advance the model for the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            chk("cmp_o_valid", bus.o_valid, phase != 0);
            chk("cmp_o_count", bus.o_count, mq.size());
            chk("cmp_drop", bus.o_drop_count, m_drop);
            chk("cmp_supersede", bus.o_supersede_count, m_sup);
            chk("cmp_overflow", bus.o_overflow, m_ovf);
            if (phase != 0) begin
                chk("cmp_o_side", bus.o_side, phase == 2);
                chk("cmp_o_stock_id", bus.o_stock_id, cur.id);
                chk("cmp_o_regs", bus.o_regs, (phase == 1) ? cur.b : cur.s);
            end
            model_step();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    function automatic bundle_t rnd_bundle();
        bundle_t r;
        for (int w = 0; w < NR; w++) r[w] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input int id, input bundle_t b, input bundle_t s);
        bus.i_valid    = v;
        bus.i_stock_id = IDW'(id);
        bus.i_regs_b   = b;
        bus.i_regs_s   = s;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((bus.o_valid || bus.o_count != 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("wait_idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic single_quote(input string tag);
        bundle_t b = rnd_bundle();
        bundle_t s = rnd_bundle();
        set_in(1, 2, b, s);
        tick();
        set_in(0, 0, '0, '0);
        chk({tag, "_valid_k"}, bus.o_valid, 1'b0);
        chk({tag, "_count_k"}, bus.o_count, 1);
        tick();
        chk({tag, "_valid_k1"}, bus.o_valid, 1'b1);
        chk({tag, "_side_buy"}, bus.o_side, 1'b0);
        chk({tag, "_id_buy"}, bus.o_stock_id, 2);
        chk({tag, "_regs_buy"}, bus.o_regs, b);
        chk({tag, "_count_k1"}, bus.o_count, 0);
        tick();
        chk({tag, "_side_sell"}, bus.o_side, 1'b1);
        chk({tag, "_id_sell"}, bus.o_stock_id, 2);
        chk({tag, "_regs_sell"}, bus.o_regs, s);
        tick();
        chk({tag, "_valid_idle"}, bus.o_valid, 1'b0);
        chk({tag, "_count_idle"}, bus.o_count, 0);
    endtask

    initial begin
        bundle_t b1, s1, b2, s2;
        int      got[$];
        int      exp_order[10] = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 15};
        bit      injected, found;

        rst_n = 1'b0;
        set_in(0, 0, '0, '0);
        bus.i_ready       = 1'b1;
        bus.i_enable_mask = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.o_valid, 1'b0);
        chk("rst_side", bus.o_side, 1'b0);
        chk("rst_regs", bus.o_regs, '0);
        chk("rst_id", bus.o_stock_id, 0);
        chk("rst_count", bus.o_count, 0);
        chk("rst_drop", bus.o_drop_count, 0);
        chk("rst_sup", bus.o_supersede_count, 0);
        chk("rst_ovf", bus.o_overflow, 1'b0);
        rst_n = 1'b1;

        single_quote("sq1");

        // Same symbol arriving as its head entry is popped: appended, not superseded.
        b1 = rnd_bundle(); s1 = rnd_bundle(); b2 = rnd_bundle(); s2 = rnd_bundle();
        set_in(1, 4, b1, s1);
        tick();
        set_in(1, 4, b2, s2);
        tick();
        set_in(0, 0, '0, '0);
        chk("popsame_count", bus.o_count, 1);
        chk("popsame_sup", bus.o_supersede_count, 0);
        chk("popsame_regs_old", bus.o_regs, b1);
        wait_idle(50);

        // Supersede while stock 1 is stalled in flight.
        bus.i_ready = 1'b0;
        set_in(1, 1, rnd_bundle(), rnd_bundle());
        tick();
        b1 = rnd_bundle(); b1[0] = 32'h100;
        set_in(1, 3, b1, rnd_bundle());
        tick();
        b2 = rnd_bundle(); b2[0] = 32'h200;
        set_in(1, 3, b2, rnd_bundle());
        tick();
        set_in(0, 0, '0, '0);
        chk("sup_inflight_id", bus.o_stock_id, 1);
        chk("sup_count", bus.o_count, 1);
        chk("sup_counter", bus.o_supersede_count, 1);
        bus.i_ready = 1'b1;
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            tick();
            if (bus.o_valid && !bus.o_side && bus.o_stock_id == 3) found = 1;
        end
        chk("sup_found", found, 1'b1);
        chk("sup_word0", bus.o_regs[0], 32'h200);
        wait_idle(50);

        // Overflow: stock 5 in flight, eight queued, ninth dropped.
        bus.i_ready = 1'b0;
        set_in(1, 5, rnd_bundle(), rnd_bundle());
        tick();
        set_in(0, 0, '0, '0);
        tick();
        for (int i = 6; i <= 13; i++) begin
            set_in(1, i, rnd_bundle(), rnd_bundle());
            tick();
        end
        set_in(1, 14, rnd_bundle(), rnd_bundle());
        tick();
        set_in(0, 0, '0, '0);
        chk("ovf_count", bus.o_count, 8);
        chk("ovf_drop", bus.o_drop_count, 1);
        chk("ovf_flag", bus.o_overflow, 1'b1);
        // Drain; a new symbol arriving while full but popping is accepted.
        bus.i_ready = 1'b1;
        injected = 0;
        for (int n = 0; n < 60 && got.size() < 10; n++) begin
            if (bus.o_valid && !bus.o_side) got.push_back(int'(bus.o_stock_id));
            if (!injected && bus.o_valid && bus.o_side && bus.o_stock_id == 5) begin
                set_in(1, 15, rnd_bundle(), rnd_bundle());
                injected = 1;
            end else begin
                set_in(0, 0, '0, '0);
            end
            tick();
        end
        set_in(0, 0, '0, '0);
        chk("ovf_order_len", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++)
            chk($sformatf("ovf_order[%0d]", i), got[i], exp_order[i]);
        wait_idle(50);
        chk("ovf_drop_after", bus.o_drop_count, 1);

        // Disabled symbol is ignored.
        bus.i_enable_mask = 16'hFFFE;
        set_in(1, 0, rnd_bundle(), rnd_bundle());
        tick();
        set_in(0, 0, '0, '0);
        chk("mask_count", bus.o_count, 0);
        tick();
        chk("mask_valid", bus.o_valid, 1'b0);
        chk("mask_drop", bus.o_drop_count, 1);
        chk("mask_sup", bus.o_supersede_count, 1);
        bus.i_enable_mask = '1;

        // Random traffic: alternating then random backpressure, random masks late.
        for (int c = 0; c < 500; c++) begin
            bus.i_ready = (c < 250) ? c[0] : 1'($urandom);
            if (c >= 400) bus.i_enable_mask = 16'($urandom);
            set_in(($urandom % 3) != 0, $urandom_range(0, (c < 250) ? 5 : 15),
                   rnd_bundle(), rnd_bundle());
            tick();
        end
        set_in(0, 0, '0, '0);
        bus.i_enable_mask = '1;
        bus.i_ready = 1'b1;
        wait_idle(200);

        // Reset while the sell beat is stalled.
        bus.i_ready = 1'b0;
        set_in(1, 7, rnd_bundle(), rnd_bundle());
        tick();
        set_in(1, 8, rnd_bundle(), rnd_bundle());
        tick();
        set_in(0, 0, '0, '0);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        chk("rsell_side", bus.o_side, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rsell_valid", bus.o_valid, 1'b0);
        chk("rsell_side0", bus.o_side, 1'b0);
        chk("rsell_regs", bus.o_regs, '0);
        chk("rsell_id", bus.o_stock_id, 0);
        chk("rsell_count", bus.o_count, 0);
        chk("rsell_drop", bus.o_drop_count, 0);
        chk("rsell_sup", bus.o_supersede_count, 0);
        chk("rsell_ovf", bus.o_overflow, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        single_quote("sq2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
